// File: rtl/generic_tdp_ram_clr_pkg.sv
// ---------------------------------------------------------------------------
// generic_ram_pkg
// Shared definitions for the generic_tdp_ram_clr true dual-port RAM:
//   - byte_en_w()     : width of the byte-enable bus for a given data width
//   - even_parity8()  : even-parity bit of one byte
//   - RDW_NEW/RDW_OLD : encodings of the read-during-write mode parameter
//   - clr_state_t     : clear-engine FSM states (IDLE / CLEAR)
// ---------------------------------------------------------------------------
package generic_ram_pkg;

  // Read-during-write mode encodings (3-character strings packed in 24 bits).
  localparam logic [23:0] RDW_NEW = "NEW";
  localparam logic [23:0] RDW_OLD = "OLD";

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // "YES" -> one enable per byte, anything else -> one enable for the word.
  function automatic int byte_en_w(input int dw, input logic [23:0] byte_wr_en);
    return (byte_wr_en == "YES") ? (dw / 8) : 1;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity8(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/generic_tdp_ram_clr_if.sv
// ---------------------------------------------------------------------------
// generic_tdp_ram_clr_if
// Bundles the clear-engine handshake and both RAM ports.
//   clr_req / ready                 : clear request and "no clear running"
//   data_x, addr_x, byteena_x       : write data, address, byte enables
//   we_x, rd_x                      : write / read strobes
//   q_x, q_valid_x                  : read data and its valid flag
//   par_err_x                       : parity error (GENERIC_RAM_PARITY_EN only)
// modport master drives requests (user side), modport slave is the RAM.
// ---------------------------------------------------------------------------
interface generic_tdp_ram_clr_if #(
  parameter int Dw   = 32,
  parameter int Aw   = 6,
  parameter int BE_W = 4
);
  logic            clr_req;
  logic            ready;
  logic [Dw-1:0]   data_a;
  logic [Dw-1:0]   data_b;
  logic [Aw-1:0]   addr_a;
  logic [Aw-1:0]   addr_b;
  logic [BE_W-1:0] byteena_a;
  logic [BE_W-1:0] byteena_b;
  logic            we_a;
  logic            we_b;
  logic            rd_a;
  logic            rd_b;
  logic [Dw-1:0]   q_a;
  logic [Dw-1:0]   q_b;
  logic            q_valid_a;
  logic            q_valid_b;
`ifdef GENERIC_RAM_PARITY_EN
  logic            par_err_a;
  logic            par_err_b;
`endif

  modport master (
    output clr_req, data_a, data_b, addr_a, addr_b, byteena_a, byteena_b,
           we_a, we_b, rd_a, rd_b,
    input  ready, q_a, q_b, q_valid_a, q_valid_b
`ifdef GENERIC_RAM_PARITY_EN
    , input par_err_a, par_err_b
`endif
  );

  modport slave (
    input  clr_req, data_a, data_b, addr_a, addr_b, byteena_a, byteena_b,
           we_a, we_b, rd_a, rd_b,
    output ready, q_a, q_b, q_valid_a, q_valid_b
`ifdef GENERIC_RAM_PARITY_EN
    , output par_err_a, par_err_b
`endif
  );

endinterface

// File: rtl/generic_tdp_ram_clr_rd_pipe.sv
// ---------------------------------------------------------------------------
// ram_rd_pipe
// Per-port read output stage. Registers the read word once (RD_LATENCY=1)
// or twice (RD_LATENCY=2). Valid bits shift every cycle; data registers only
// load when their input is valid, so q holds its last value between reads.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (flushes valids,
//                        clears data)
//   in_valid, in_data  : read accepted this cycle and the word read
//   q, q_valid         : registered read data and its valid flag
// Any RD_LATENCY other than 2 builds the single-stage version.
// ---------------------------------------------------------------------------
module ram_rd_pipe #(
  parameter int Dw         = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [Dw-1:0] in_data,
  output logic [Dw-1:0] q,
  output logic          q_valid
);

  logic [Dw-1:0] s1_data_reg;
  logic          s1_valid_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data_reg  <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg <= in_data;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [Dw-1:0] s2_data_reg;
      logic          s2_valid_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2_data_reg  <= '0;
          s2_valid_reg <= 1'b0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign q       = s2_data_reg;
      assign q_valid = s2_valid_reg;
    end else begin : g_lat1
      assign q       = s1_data_reg;
      assign q_valid = s1_valid_reg;
    end
  endgenerate

endmodule

// File: rtl/generic_tdp_ram_clr.sv
// ---------------------------------------------------------------------------
// generic_tdp_ram_clr
// True dual-port single-clock RAM with per-byte write enables, selectable
// read latency, defined read-during-write / collision behaviour and a clear
// engine that sweeps CLR_VALUE into every word after reset or on clr_req.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high; flushes read pipes, starts a sweep
//   bus    : generic_tdp_ram_clr_if.slave (clr_req/ready and ports A/B)
// Behaviour notes:
//   - While ready=0 (sweep running) or reset=1, we/rd/clr_req are ignored.
//   - Same-port read+write: RDW_MODE "NEW" returns the merged word, "OLD"
//     the previous contents. Cross-port reads always see the old contents.
//   - Both ports writing one address: A's enabled bytes win, B fills the rest.
// Optional feature, macro GENERIC_RAM_PARITY_EN: one even-parity bit per byte
// lane is stored with the data; par_err_a/b flag a mismatch with q_valid.
// ---------------------------------------------------------------------------
module generic_tdp_ram_clr
  import generic_ram_pkg::*;
#(
  parameter int          Dw         = 32,
  parameter int          Aw         = 6,
  parameter logic [23:0] BYTE_WR_EN = "YES",
  parameter int          RD_LATENCY = 1,
  parameter logic [23:0] RDW_MODE   = "NEW",
  parameter logic [Dw-1:0] CLR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  generic_tdp_ram_clr_if.slave  bus
);

  localparam int BE_W  = byte_en_w(Dw, BYTE_WR_EN);
  localparam int LW    = Dw / BE_W;            // bits per enable lane
  localparam int DEPTH = 2 ** Aw;
  localparam bit RDW_IS_NEW = (RDW_MODE == RDW_NEW);
  localparam logic [Aw:0] CLR_LAST = (Aw + 1)'(DEPTH - 1);

`ifdef GENERIC_RAM_PARITY_EN
  localparam int PW = Dw + BE_W;               // data + lane parity bits
`else
  localparam int PW = Dw;
`endif

  // -------------------------------------------------------------------------
  // Clear engine
  // -------------------------------------------------------------------------
  clr_state_t  state_reg, state_next;
  // One bit wider than the address so the terminal compare never wraps.
  logic [Aw:0] clr_addr_reg, clr_addr_next;
  logic        ready;
  logic        port_en;
  logic        clearing;
  logic [Aw-1:0] clr_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.clr_req) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      CLEAR: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == CLR_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next    = CLEAR;
        clr_addr_next = '0;
      end
    endcase
  end

  assign ready     = (state_reg == IDLE);
  assign bus.ready = ready;
  // The reset edge itself must not accept port traffic or clear a word.
  assign port_en   = ready && !reset;
  assign clearing  = (state_reg == CLEAR) && !reset;
  assign clr_idx   = clr_addr_reg[Aw-1:0];

  // -------------------------------------------------------------------------
  // Qualified port strobes
  // -------------------------------------------------------------------------
  logic wr_a, wr_b, rd_a, rd_b;

  assign wr_a = port_en && bus.we_a;
  assign wr_b = port_en && bus.we_b;
  assign rd_a = port_en && bus.rd_a;
  assign rd_b = port_en && bus.rd_b;

  // -------------------------------------------------------------------------
  // Storage. Port B lanes are written first so that port A lanes, assigned
  // later in the same block, take priority on an address collision.
  // -------------------------------------------------------------------------
  logic [Dw-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_idx] <= CLR_VALUE;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_b && bus.byteena_b[i]) begin
          mem[bus.addr_b][i*LW +: LW] <= bus.data_b[i*LW +: LW];
        end
      end
      for (int i = 0; i < BE_W; i++) begin
        if (wr_a && bus.byteena_a[i]) begin
          mem[bus.addr_a][i*LW +: LW] <= bus.data_a[i*LW +: LW];
        end
      end
    end
  end

  // Old contents at each port address (before this cycle's writes).
  logic [Dw-1:0] old_a, old_b;
  logic [Dw-1:0] rd_word_a, rd_word_b;

  assign old_a = mem[bus.addr_a];
  assign old_b = mem[bus.addr_b];

  // Same-port merge for "NEW" mode; the other port's write is never visible.
  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_rd_merge
      assign rd_word_a[gi*LW +: LW] =
        (RDW_IS_NEW && wr_a && bus.byteena_a[gi]) ? bus.data_a[gi*LW +: LW]
                                                  : old_a[gi*LW +: LW];
      assign rd_word_b[gi*LW +: LW] =
        (RDW_IS_NEW && wr_b && bus.byteena_b[gi]) ? bus.data_b[gi*LW +: LW]
                                                  : old_b[gi*LW +: LW];
    end
  endgenerate

  logic [PW-1:0] pipe_in_a, pipe_in_b;
  logic [PW-1:0] pipe_out_a, pipe_out_b;

`ifdef GENERIC_RAM_PARITY_EN
  // -------------------------------------------------------------------------
  // Parity: one bit per enable lane, written and cleared alongside the data.
  // -------------------------------------------------------------------------
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] wpar_a, wpar_b, clr_par;
  logic [BE_W-1:0] old_par_a, old_par_b, rd_par_a, rd_par_b;
  logic [BE_W-1:0] chk_par_a, chk_par_b;

  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_par
      if (LW == 8) begin : g_byte
        assign wpar_a[gi]    = even_parity8(bus.data_a[gi*8 +: 8]);
        assign wpar_b[gi]    = even_parity8(bus.data_b[gi*8 +: 8]);
        assign clr_par[gi]   = even_parity8(CLR_VALUE[gi*8 +: 8]);
        assign chk_par_a[gi] = even_parity8(pipe_out_a[gi*8 +: 8]);
        assign chk_par_b[gi] = even_parity8(pipe_out_b[gi*8 +: 8]);
      end else begin : g_word
        assign wpar_a[gi]    = ^bus.data_a[gi*LW +: LW];
        assign wpar_b[gi]    = ^bus.data_b[gi*LW +: LW];
        assign clr_par[gi]   = ^CLR_VALUE[gi*LW +: LW];
        assign chk_par_a[gi] = ^pipe_out_a[gi*LW +: LW];
        assign chk_par_b[gi] = ^pipe_out_b[gi*LW +: LW];
      end
      assign rd_par_a[gi] = (RDW_IS_NEW && wr_a && bus.byteena_a[gi]) ? wpar_a[gi]
                                                                      : old_par_a[gi];
      assign rd_par_b[gi] = (RDW_IS_NEW && wr_b && bus.byteena_b[gi]) ? wpar_b[gi]
                                                                      : old_par_b[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clearing) begin
      par_mem[clr_idx] <= clr_par;
    end else begin
      for (int i = 0; i < BE_W; i++) begin
        if (wr_b && bus.byteena_b[i]) begin
          par_mem[bus.addr_b][i] <= wpar_b[i];
        end
      end
      for (int i = 0; i < BE_W; i++) begin
        if (wr_a && bus.byteena_a[i]) begin
          par_mem[bus.addr_a][i] <= wpar_a[i];
        end
      end
    end
  end

  assign old_par_a = par_mem[bus.addr_a];
  assign old_par_b = par_mem[bus.addr_b];
  assign pipe_in_a = {rd_par_a, rd_word_a};
  assign pipe_in_b = {rd_par_b, rd_word_b};

  assign bus.par_err_a = bus.q_valid_a && (chk_par_a != pipe_out_a[Dw +: BE_W]);
  assign bus.par_err_b = bus.q_valid_b && (chk_par_b != pipe_out_b[Dw +: BE_W]);
`else
  assign pipe_in_a = rd_word_a;
  assign pipe_in_b = rd_word_b;
`endif

  // -------------------------------------------------------------------------
  // Output stages
  // -------------------------------------------------------------------------
  ram_rd_pipe #(
    .Dw         (PW),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_a),
    .in_data  (pipe_in_a),
    .q        (pipe_out_a),
    .q_valid  (bus.q_valid_a)
  );

  ram_rd_pipe #(
    .Dw         (PW),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_b),
    .in_data  (pipe_in_b),
    .q        (pipe_out_b),
    .q_valid  (bus.q_valid_b)
  );

  assign bus.q_a = pipe_out_a[Dw-1:0];
  assign bus.q_b = pipe_out_b[Dw-1:0];

endmodule
